// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start bit, 8 data + odd parity + stop on device clock falls, then ack.
// Latency ~inhibit_cycles + 11 device clocks; a trigger while busy is dropped, not queued.
module ps2_host_tx #(
  parameter int CLOCK_FILTER   = 24,
  parameter int INHIBIT_CYCLES = 10800,
  parameter int TIMEOUT_CYCLES = 1611000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       send_trigger,
  input  logic [7:0] send_byte,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FW   = $clog2(CLOCK_FILTER + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(CLOCK_FILTER - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, fall_q;
  logic [FW-1:0] fcnt_q;

  // Pads idle high, so the synchronisers and filter come out of reset high to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat_in;
      dat_s2_q <= dat_s1_q;
      fall_q   <= 1'b0;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FLT_LAST) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
        fall_q <= filt_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          done_q, done_d, error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        if (send_trigger) begin
          frame_d  = {1'b1, ~^send_byte, send_byte};
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      // Clock is held low for INHIBIT_CYCLES in total; the start bit goes out on its last cycle.
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        clk_oe_d = 1'b0;
        bit_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (fall_q) begin
          dat_oe_d = ~frame_q[bit_q];
          if (bit_q == 4'd9) state_d = ACK;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      ACK: begin
        if (fall_q) begin
          if (dat_s2_q) begin
            error_d  = 1'b1;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (filt_q && dat_s2_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout overrides any completion in the same cycle so only one pulse is emitted.
    if (state_q inside {RELEASE, SHIFT, ACK, WAIT_IDLE}) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TMO_LAST) begin
        cnt_d    = '0;
        done_d   = 1'b0;
        error_d  = 1'b1;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND pads, a behavioural PS/2 device and a byte scoreboard.
module tb_ps2_host_tx;
  localparam int FILT = 24;
  localparam int INH  = 200;
  localparam int TMO  = 4000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0, glitch = 1'b0;
  logic       send_trigger = 1'b0;
  logic [7:0] send_byte = 8'h00;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe, busy, done, error;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.CLOCK_FILTER(FILT), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .send_trigger(send_trigger),
    .send_byte(send_byte), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int tests_run = 0, fails = 0;
  logic [7:0] exp_q[$];

  int cyc = 0, done_cnt = 0, err_cnt = 0, clk_run = 0, last_clk_run = 0, rel_cyc = 0, err_cyc = 0;
  logic prev_dat_oe = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (error) begin err_cnt++; err_cyc = cyc; end
    if (ps2_clk_oe) clk_run++;
    else if (clk_run != 0) begin last_clk_run = clk_run; clk_run = 0; end
    if (ps2_dat_oe && !prev_dat_oe && ps2_clk_oe) rel_cyc = cyc;
    prev_dat_oe = ps2_dat_oe;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    send_byte = b;
    send_trigger = 1'b1;
    @(negedge clk);
    send_trigger = 1'b0;
  endtask

  // Device side: waits for the start bit, clocks 11 pulses, samples host data at each rising edge.
  task automatic dev_frame(input bit ack, input int abort_after, input bit glitch_en,
                           output logic [10:0] bits, output bit ok);
    int t = 0;
    ok = 1'b0;
    bits = '0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && t < 20000) begin @(negedge clk); t++; end
    if (t >= 20000) return;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) dev_dat_low = ack;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 10) bits[i] = ps2_dat_in;
      if (abort_after == i + 1) begin ok = 1'b1; return; end
      if (glitch_en && i == 3) begin
        repeat (30) @(negedge clk);
        glitch = 1'b1;
        repeat (10) @(negedge clk);
        glitch = 1'b0;
      end
      repeat (HALF) @(negedge clk);
    end
    dev_dat_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin fails++; $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_dat_oe}); end
    tests_run++; if ({busy, done, error} !== 3'b000) begin fails++; $display("FAIL reset_status: got %b expected 000", {busy, done, error}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    tests_run++; if ({ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 5'b0) begin fails++; $display("FAIL idle_after_reset: got %b expected 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, error}); end
  endtask

  task automatic test_send(input logic [7:0] b, input bit glitch_en);
    logic [10:0] bits;
    logic [7:0]  e;
    bit          ok;
    int d0 = done_cnt, e0 = err_cnt, t = 0;
    exp_q.push_back(b);
    send(b);
    dev_frame(1'b1, 0, glitch_en, bits, ok);
    while (busy && t < 2000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    tests_run++; if (!ok || t >= 2000) begin fails++; $display("FAIL send_%h_timeout: got ok=%0d wait=%0d expected ok=1 wait<2000", b, ok, t); end
    tests_run++; if (last_clk_run !== INH) begin fails++; $display("FAIL send_%h_inhibit: got %0d cycles expected %0d", b, last_clk_run, INH); end
    if (exp_q.size() == 0) begin
      tests_run++; fails++; $display("FAIL send_%h_scoreboard: got empty queue expected one entry", b);
    end else begin
      e = exp_q.pop_front();
      tests_run++; if (bits[7:0] !== e) begin fails++; $display("FAIL send_%h_data: got %h expected %h", b, bits[7:0], e); end
      tests_run++; if (bits[8] !== (($countones(e) % 2 == 0) ? 1'b1 : 1'b0)) begin fails++; $display("FAIL send_%h_parity: got %b for %h", b, bits[8], e); end
      tests_run++; if (bits[9] !== 1'b1) begin fails++; $display("FAIL send_%h_stop: got %b expected 1", b, bits[9]); end
    end
    tests_run++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin fails++; $display("FAIL send_%h_pulses: got done=%0d err=%0d expected 1 0", b, done_cnt - d0, err_cnt - e0); end
    tests_run++; if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin fails++; $display("FAIL send_%h_idle: got %b expected 000", b, {busy, ps2_clk_oe, ps2_dat_oe}); end
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'hFF);
    dev_frame(1'b0, 0, 1'b0, bits, ok);
    repeat (20) @(negedge clk);
    tests_run++; if (!ok || bits[7:0] !== 8'hFF) begin fails++; $display("FAIL noack_frame: got ok=%0d data=%h expected 1 ff", ok, bits[7:0]); end
    tests_run++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin fails++; $display("FAIL noack_pulses: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0); end
    tests_run++; if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin fails++; $display("FAIL noack_idle: got %b expected 000", {busy, ps2_clk_oe, ps2_dat_oe}); end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt, e0 = err_cnt, t = 0;
    send(8'hA5);
    while (err_cnt == e0 && t < INH + TMO + 500) begin @(negedge clk); t++; end
    @(negedge clk);
    tests_run++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_error: got %0d pulses expected 1", err_cnt - e0); end
    tests_run++; if (err_cyc - rel_cyc !== TMO) begin fails++; $display("FAIL timeout_latency: got %0d expected %0d", err_cyc - rel_cyc, TMO); end
    tests_run++; if ({done_cnt - d0 != 0, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b0000) begin fails++; $display("FAIL timeout_idle: got %b expected 0000", {done_cnt - d0 != 0, busy, ps2_clk_oe, ps2_dat_oe}); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    logic [7:0]  e;
    bit ok;
    int d0 = done_cnt, idle_busy = 0;
    exp_q.push_back(8'hF3);
    @(negedge clk);
    send_byte = 8'hF3;
    send_trigger = 1'b1;
    @(negedge clk);
    send_byte = 8'h55;
    fork
      dev_frame(1'b1, 0, 1'b0, bits, ok);
      begin
        for (int t = 0; t < 5000; t++) begin
          send_trigger = busy;
          if (!busy) break;
          @(negedge clk);
        end
        send_trigger = 1'b0;
      end
    join
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (!ok || bits[7:0] !== e) begin fails++; $display("FAIL b2b_data: got %h expected %h", bits[7:0], e); end
    tests_run++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL b2b_done: got %0d expected 1", done_cnt - d0); end
    tests_run++; if (idle_busy !== 0) begin fails++; $display("FAIL b2b_no_restart: got %0d busy cycles expected 0", idle_busy); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    bit ok;
    send(8'h2C);
    dev_frame(1'b1, 5, 1'b0, bits, ok);
    tests_run++; if (!ok || ps2_dat_oe !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL mid_bit4: got ok=%0d dat_oe=%b busy=%b expected 1 1 1", ok, ps2_dat_oe, busy); end
    #3 rst_n = 1'b0;
    #1;
    tests_run++; if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin fails++; $display("FAIL mid_async_reset: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    test_send(8'h96, 1'b1);
  endtask

  initial begin
    test_reset();
    test_send(8'hED, 1'b0);
    test_send(8'h00, 1'b0);
    test_send(8'h01, 1'b0);
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    tests_run++; if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
